// File: rtl/cla_pkg.sv
// cla_pkg: shared FSM state type, nibble width and counter-width helper for cla_seq_adder
package cla_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIB_W = 4;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit lookahead slice; in a,b,c0; out s, c4, c3 (carry into bit 3)
module cla4_slice
  import cla_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             c0,
  output logic [NIB_W-1:0] s,
  output logic             c4,
  output logic             c3
);
  logic [3:0] p, g;
  logic c1, c2;
  assign p  = a ^ b;
  assign g  = a & b;
  assign c1 = g[0] | p[0] & c0;
  assign c2 = g[1] | p[1] & g[0] | p[1] & p[0] & c0;
  assign c3 = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & c0;
  assign c4 = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0]
            | p[3] & p[2] & p[1] & p[0] & c0;
  assign s  = p ^ {c3, c2, c1, c0};
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: nibble-serial CLA add/sub; ports clk rst_n, in_valid/in_ready a b cin op_sub, out_valid/out_ready sum cout busy, ovf when CLA_SEQ_OVF_EN
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CLA_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);
  localparam int NUM_NIB = WIDTH / NIB_W;
  localparam int CW = cnt_w(NUM_NIB);
  state_t st;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0] idx;
  logic cy, c4, c3;
  logic [NIB_W-1:0] s;
  logic last;
  assign last = idx == CW'(NUM_NIB - 1);
  cla4_slice u_slice (
    .a (a_r[idx*NIB_W +: NIB_W]),
    .b (b_r[idx*NIB_W +: NIB_W]),
    .c0(cy),
    .s (s),
    .c4(c4),
`ifdef CLA_SEQ_OVF_EN
    .c3(c3)
`else
    .c3()
`endif
  );
`ifndef CLA_SEQ_OVF_EN
  assign c3 = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      cy        <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          a_r      <= a;
          b_r      <= op_sub ? ~b : b;
          cy       <= op_sub | cin;
          idx      <= '0;
          st       <= RUN;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          sum[idx*NIB_W +: NIB_W] <= s;
          cy <= c4;
          if (last) begin
            st        <= DONE;
            out_valid <= 1'b1;
            cout      <= c4;
`ifdef CLA_SEQ_OVF_EN
            ovf       <= c3 ^ c4;
`endif
          end else idx <= idx + 1'b1;
        end
        DONE: if (out_ready) begin
          st        <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: directed self-checking bench for cla_seq_adder at WIDTH=16
module tb_cla_seq_adder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, op_sub = 1'b0;
  logic [15:0] a = '0, b = '0, sum;
  logic in_ready, out_valid, cout, busy;
  int errs = 0, checks = 0;
`ifdef CLA_SEQ_OVF_EN
  logic ovf;
`endif
  cla_seq_adder #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .op_sub   (op_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
`ifdef CLA_SEQ_OVF_EN
    .ovf      (ovf),
`endif
    .busy     (busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic sub);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_before_op", in_ready, 1);
    a = av; b = bv; cin = c; op_sub = sub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF;
  endtask
  task automatic wait_result(input string tag, input logic [15:0] es, input logic ec);
    repeat (3) tick();
    check({tag, "_early_valid"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_busy"}, busy, 1);
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
  endtask
  task automatic op(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic c,
                    input logic sub, input logic [15:0] es, input logic ec);
    start_op(av, bv, c, sub);
    wait_result(tag, es, ec);
    release_out();
  endtask
  initial begin
    logic seen;
    repeat (2) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    tick();
    op("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    op("ripple_b", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    op("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_result("bp", 16'h0100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
      tick();
      check("bp_hold_sum", sum, 16'h0100);
      check("bp_hold_cout", cout, 0);
      check("bp_hold_in_ready", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_rel_in_ready", in_ready, 1);
    check("bp_rel_out_valid", out_valid, 0);
    check("bp_rel_busy", busy, 0);
    tick();
    check("bp_no_accept_busy", busy, 0);
    start_op(16'h1111, 16'h1111, 1'b0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check("mid_rst_no_valid", seen, 0);
    op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
`ifdef CLA_SEQ_OVF_EN
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_result("ovf_pos", 16'h8000, 1'b0);
    check("ovf_pos_flag", ovf, 1);
    release_out();
    start_op(16'h8000, 16'hFFFF, 1'b0, 1'b0);
    wait_result("ovf_neg", 16'h7FFF, 1'b1);
    check("ovf_neg_flag", ovf, 1);
    release_out();
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_result("ovf_none", 16'h5555, 1'b0);
    check("ovf_none_flag", ovf, 0);
    release_out();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle N-bit adder/subtractor that time-shares one 4-bit carry-lookahead slice across all nibbles of its operands. It processes one nibble per clock, least significant first, and carries the nibble carry in a register between cycles. It sits between an upstream operand producer and a downstream result consumer, with valid/ready handshakes on both sides. It is the area-saving alternative to a full-width lookahead adder.

## Interface
- WIDTH, default 16: operand width in bits; must be a multiple of 4 and at least 4. NUM_NIB = WIDTH/4.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand transfer request
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for add; ignored when op_sub=1
- op_sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out of the MSB nibble (for subtract: 1 = no borrow)
- busy  output  1  state != IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: register a, b_eff (b, or ~b when op_sub=1), and carry reg (cin, or 1 when op_sub=1).
  - Clear nibble counter and go to RUN.
- RUN, each cycle, with idx = nibble counter:
  - Feed the slice a[4*idx+:4], b_eff[4*idx+:4] and the carry reg.
  - Write the slice sum into sum[4*idx+:4] and the slice carry into the carry reg.
  - If idx == NUM_NIB-1: go to DONE. Otherwise increment idx.
- DONE:
  - out_valid=1. cout = carry reg.
  - sum and cout are held stable while out_ready=0.
  - On out_ready: go to IDLE.
- Operand registers are not updated outside IDLE, so input changes during RUN/DONE have no effect.
- Arithmetic:
  - Modulo 2^WIDTH.
  - The slice computes p=a^b, g=a&b, and the full lookahead carries c1..c4, where c4 = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0 | p3&p2&p1&p0&c0.
  - Nibble sum = p ^ {c3,c2,c1,c0}.
- The nibble counter is $clog2(NUM_NIB) bits wide, minimum 1. It does not wrap past NUM_NIB-1.
- Reset, asserted at any time including mid-RUN or in DONE:
  - Any operation in flight is aborted and its result discarded.
  - State goes to IDLE.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0, carry reg=0, counter=0.
- Latency: input handshake at edge k; out_valid rises after edge k+NUM_NIB (NUM_NIB RUN cycles).
- Throughput: one result per NUM_NIB+2 cycles when out_ready is held high (accept, NUM_NIB x RUN, DONE).
- No bypass:
  - in_ready rises the cycle after the output handshake.
  - in_ready and out_valid are never high together.
- out_valid does not depend combinationally on out_ready. in_ready does not depend combinationally on in_valid.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes. New operands are taken at the earliest on the next cycle.
- Outputs are registered. sum nibbles update one per RUN cycle; the bench samples them only when out_valid=1.

## Configuration
- CLA_SEQ_OVF_EN defined:
  - Adds output port ovf (1 bit) = signed two's-complement overflow.
  - ovf = carry into the MSB XOR carry out of the MSB, taken from the slice on the last RUN cycle.
  - ovf is registered, valid with out_valid, and reset to 0.
- CLA_SEQ_OVF_EN undefined: no ovf port and no related logic.

## Structure
- Shared package cla_pkg holds:
  - State enum type (IDLE, RUN, DONE).
  - NIB_W = 4.
  - A function for the counter width.
- Sub-module cla4_slice: purely combinational 4-bit lookahead slice.
  - Inputs: a[3:0], b[3:0], c0.
  - Outputs: s[3:0], c4, c3. c3 is exported for overflow detection.
  - Instantiated exactly once.
- The top level holds the FSM, counter, operand/carry/result registers and the handshake logic.

## Test plan
All scenarios use WIDTH=16.
- Add: a=0x1234, b=0x4321, cin=0, op_sub=0 -> sum=0x5555, cout=0. out_valid rises exactly 4 cycles after the accept edge.
- Full carry ripple across nibbles: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Separately, a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Subtract with borrow: a=0x0005, b=0x0007, op_sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> sum and cout stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst_n=0 after 2 RUN cycles -> outputs take reset values immediately and out_valid never rises for that operation. A following add of 0x0001+0x0001 -> 0x0002.
- With CLA_SEQ_OVF_EN: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0. a=0x8000, b=0xFFFF -> sum=0x7FFF, ovf=1, cout=1.
